sha1_core: RTL
==============

SHA1_CORE -- requirements
Module: sha1_core

Interface
REQ-001 SHALL have parameter ByteSwap, default 0: when 1, each 32-bit input word is byte-reversed before use.
REQ-002 SHALL have clk_i  input  1  clock; all logic is single-clock and rising-edge.
REQ-003 SHALL have rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have block_i  input  512  message block; W0 = block_i[511:480], W15 = block_i[31:0].
REQ-005 SHALL have block_valid_i  input  1  block_i is valid.
REQ-006 SHALL have block_ready_o  output  1  core can accept a block.
REQ-007 SHALL have init_i  input  1  first block of a message; sampled with the block handshake.
REQ-008 SHALL have busy_o  output  1  core is computing.
REQ-009 SHALL have digest_o  output  160  chaining value H0..H4; H0 = digest_o[159:128].
REQ-010 SHALL have digest_valid_o  output  1  digest_o holds a completed result.
REQ-011 SHALL have digest_ack_i  input  1  consumer acknowledges the digest.

Function
REQ-012 SHALL implement the FSM states IDLE, ROUND, UPDATE and DONE.
REQ-013 SHALL drive block_ready_o = 1 only in IDLE; block_valid_i SHALL be ignored in every other state.
REQ-014 SHALL, on handshake (block_valid_i & block_ready_o), latch W0..W15 into the schedule, load a..e from H, clear the round counter t, and move to ROUND.
REQ-015 SHALL perform exactly one round per cycle in ROUND, for t = 0..79, with a 7-bit counter.
REQ-016 SHALL compute W_t for t >= 16 as rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]) in a 16-entry circular buffer indexed by t mod 16, writing in place.
REQ-017 SHALL select f and K by round range:
- t 0-19: Ch, K = 5A827999
- t 20-39: Parity, K = 6ED9EBA1
- t 40-59: Maj, K = 8F1BBCDC
- t 60-79: Parity, K = CA62C1D6
REQ-018 SHALL perform all additions modulo 2^32 and discard carries.
REQ-019 SHALL move to UPDATE after round 79, add a..e into H0..H4 modulo 2^32, then move to DONE.
REQ-020 SHALL assert digest_valid_o exactly 81 clock edges after the handshake edge.
REQ-021 SHALL keep digest_valid_o = 1 in DONE until digest_ack_i = 1, then return to IDLE on the next edge.
REQ-022 SHALL ignore digest_ack_i outside DONE.
REQ-023 SHALL drive busy_o = 1 in ROUND and UPDATE.
REQ-024 SHALL always drive digest_o from the H register, stable outside UPDATE.
REQ-025 SHALL accept a new block on the first edge after the ack edge, giving a minimum block-to-block period of 83 cycles.

Reset
REQ-026 SHALL, when rst_i = 1 on an edge, force:
- state IDLE, t = 0, schedule cleared
- H = 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0
REQ-027 SHALL give outputs after reset: block_ready_o = 1, busy_o = 0, digest_valid_o = 0, digest_o = the H0 constants.
REQ-028 SHALL let reset mid-ROUND or mid-DONE abort the operation with no partial H update.

Configuration
REQ-029 SHALL, with SHA1_CORE_CHAIN_EN defined, reload H from the H0 constants at handshake only if init_i = 1; otherwise the previous H is kept for multi-block chaining.
REQ-030 SHALL, without SHA1_CORE_CHAIN_EN, reload H from the H0 constants at every handshake and ignore init_i; the port remains.

Structure
REQ-031 SHALL place in package sha1_pkg:
- word_t (32-bit)
- H0 initial constants and K constants
- state enum
- rotl helper
REQ-032 SHALL put the message schedule (16x32 circular buffer, W_t generation) in submodule sha1_wsched; the FSM, round datapath and H register stay in sha1_core.

Verification
REQ-033 SHALL check that padded "abc" with init_i = 1 gives digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D, valid exactly 81 edges after handshake.
REQ-034 SHALL check that the padded empty message gives DA39A3EE 5E6B4B0D 3255BFEF 95601890 AFD80709.
REQ-035 SHALL check, with SHA1_CORE_CHAIN_EN, that the two blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (init_i 1 then 0) give 84983E44 1C3BD26E BAAE4AA1 F95129E5 E54670F1; without the macro, the second block alone hashes from the H0 constants.
REQ-036 SHALL check that with digest_ack_i held low 10 cycles in DONE and block_valid_i high, digest_valid_o stays 1, block_ready_o stays 0, and no block is accepted.
REQ-037 SHALL check that rst_i pulsed at round t = 40 gives IDLE, digest_o = 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0 and digest_valid_o = 0.
REQ-038 SHALL check that ByteSwap = 1 with the byte-reversed "abc" block gives the same digest as REQ-033.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared types, constants and helpers for the SHA-1 core and its message schedule.
package sha1_pkg;

   localparam int unsigned WordW  = 32;
   localparam int unsigned BlockW = 512;
   localparam int unsigned HashW  = 160;
   localparam int unsigned CountW = 7;

   typedef logic [WordW-1:0] word_t;
   typedef word_t [4:0]      hash_t;   // index 4 holds H0 so the packed value is the digest

   localparam hash_t H_INIT = HashW'(160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0);

   localparam word_t K0 = 32'h5A827999;
   localparam word_t K1 = 32'h6ED9EBA1;
   localparam word_t K2 = 32'h8F1BBCDC;
   localparam word_t K3 = 32'hCA62C1D6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUND  = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic word_t rotl(input word_t x, input int unsigned n);
      return (x << n) | (x >> (WordW - n));
   endfunction

   function automatic word_t bswap(input word_t x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/sha1_wsched.sv
// SHA-1 message schedule: 16-word circular buffer producing W_t, expanded in place for t >= 16.
module sha1_wsched
   import sha1_pkg::*;
#(
   parameter bit ByteSwap = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [BlockW-1:0] block,
   input  logic              step,
   input  logic [CountW-1:0] t,
   output word_t             w_c
);

   word_t      w_q [16];
   word_t      w_new_c;
   logic [3:0] idx;

   assign idx     = t[3:0];
   // 4-bit index arithmetic wraps modulo 16, giving t-3, t-8, t-14 and t-16 slots
   assign w_new_c = rotl(w_q[idx - 4'd3] ^ w_q[idx - 4'd8] ^ w_q[idx - 4'd14] ^ w_q[idx], 1);
   assign w_c     = (t < CountW'(16)) ? w_q[idx] : w_new_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < 16; i++)
            w_q[i] <= ByteSwap ? bswap(block[BlockW-1-WordW*i -: WordW])
                               : block[BlockW-1-WordW*i -: WordW];
      end else if (step && (t >= CountW'(16))) begin
         w_q[idx] <= w_new_c;
      end
   end

endmodule

// File: rtl/sha1_core.sv
// SHA-1 compression core: one round per cycle, 81 edges from block handshake to digest.
// Define SHA1_CORE_CHAIN_EN to keep H across blocks unless init_i marks a new message.
module sha1_core
   import sha1_pkg::*;
#(
   parameter bit ByteSwap = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [BlockW-1:0] block_i,
   input  logic              block_valid_i,
   output logic              block_ready_o,
   input  logic              init_i,
   output logic              busy_o,
   output logic [HashW-1:0]  digest_o,
   output logic              digest_valid_o,
   input  logic              digest_ack_i
);

   state_t            state_q, state_d;
   logic [CountW-1:0] t_q;
   hash_t             h_q;
   hash_t             seed_c;
   word_t             a_q, b_q, c_q, d_q, e_q;
   word_t             w_c, f_c, k_c, temp_c;
   logic              ready_q, busy_q, valid_q;
   logic              ready_d, busy_d, valid_d;
   logic              accept_c;

   assign accept_c       = block_valid_i & ready_q;
   assign block_ready_o  = ready_q;
   assign busy_o         = busy_q;
   assign digest_valid_o = valid_q;
   assign digest_o       = h_q;

   sha1_wsched #(.ByteSwap(ByteSwap)) u_wsched (
      .clk   (clk_i),
      .rst   (rst_i),
      .load  (accept_c),
      .block (block_i),
      .step  (state_q == ROUND),
      .t     (t_q),
      .w_c   (w_c)
   );

`ifdef SHA1_CORE_CHAIN_EN
   assign seed_c = init_i ? H_INIT : h_q;
`else
   logic unused_init;
   assign unused_init = init_i;
   assign seed_c      = H_INIT;
`endif

   // State register with registered status outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ready_d = 1'b0;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      unique case (state_q)
         IDLE:    if (block_valid_i) state_d = ROUND;
         ROUND:   if (t_q == CountW'(79)) state_d = UPDATE;
         UPDATE:  state_d = DONE;
         DONE:    if (digest_ack_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = (state_d == ROUND) || (state_d == UPDATE);
      valid_d = (state_d == DONE);
   end

   // Round function and constant by 20-round group
   always_comb begin
      f_c = b_q ^ c_q ^ d_q;
      k_c = K1;
      if (t_q < CountW'(20)) begin
         f_c = (b_q & c_q) | (~b_q & d_q);
         k_c = K0;
      end else if (t_q < CountW'(40)) begin
         k_c = K1;
      end else if (t_q < CountW'(60)) begin
         f_c = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
         k_c = K2;
      end else begin
         k_c = K3;
      end
   end

   assign temp_c = rotl(a_q, 5) + f_c + e_q + k_c + w_c;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         t_q <= '0;
         h_q <= H_INIT;
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         d_q <= '0;
         e_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (block_valid_i) begin
                  t_q <= '0;
                  h_q <= seed_c;
                  a_q <= seed_c[4];
                  b_q <= seed_c[3];
                  c_q <= seed_c[2];
                  d_q <= seed_c[1];
                  e_q <= seed_c[0];
               end
            end
            ROUND: begin
               a_q <= temp_c;
               b_q <= a_q;
               c_q <= rotl(b_q, 30);
               d_q <= c_q;
               e_q <= d_q;
               t_q <= t_q + CountW'(1);
            end
            UPDATE: begin
               h_q <= {h_q[4] + a_q, h_q[3] + b_q, h_q[2] + c_q, h_q[1] + d_q, h_q[0] + e_q};
            end
            default: ;
         endcase
      end
   end

endmodule
